qsys_shield_gpio_funcsel_bank: RTL and testbench

- Multi-pin GPIO function-select bank with an Avalon-MM slave.
- Each of N_PINS shield pins routes one of N_FUNCS peripheral (oe, out) pairs to its tri-state pad.
- Adds behaviour the single-pin selector lacks: break-before-make guard on function change, 2-FF input synchronisers, per-pin edge capture and a maskable interrupt.
- Sits between Qsys peripheral conduits and the shield header pins.

---
 rtl/qsys_shield_gpio_funcsel_bank.sv | 135 +++++++++++++
 tb/tb_qsys_shield_gpio_funcsel_bank.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_shield_gpio_funcsel_bank.sv
// GPIO function-select bank: routes one peripheral (oe, out) pair per pin to its pad, with break-before-make guard, synced inputs and edge IRQ.
// Avalon-MM reads have fixed latency 1; waitrequest is tied low, so the bus is never stalled.
module qsys_shield_gpio_funcsel_bank #(
    parameter int N_PINS       = 8,
    parameter int N_FUNCS      = 8,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                        csi_MCLK_clk,
    input  logic                        rsi_MRST_reset,
    input  logic [4:0]                  avs_ctrl_address,
    input  logic [31:0]                 avs_ctrl_writedata,
    output logic [31:0]                 avs_ctrl_readdata,
    input  logic                        avs_ctrl_write,
    input  logic                        avs_ctrl_read,
    output logic                        avs_ctrl_waitrequest,
    output logic                        ins_irq_irq,
    input  logic [N_PINS*N_FUNCS-1:0]   coe_f_oe,
    input  logic [N_PINS*N_FUNCS-1:0]   coe_f_out,
    output logic [N_PINS-1:0]           coe_f_in,
    inout  wire  [N_PINS-1:0]           coe_GPIO
);
    localparam int               SEL_W   = (N_FUNCS > 1) ? $clog2(N_FUNCS) : 1;
    localparam logic [SEL_W:0]   NF_L    = (SEL_W + 1)'(N_FUNCS);
    localparam logic [7:0]       GUARD_L = 8'(GUARD_CYCLES);

    logic [SEL_W-1:0]  sel_q   [N_PINS];
    logic [SEL_W-1:0]  sel_d   [N_PINS];
    logic [7:0]        guard_q [N_PINS];
    logic [7:0]        guard_d [N_PINS];
    logic [N_PINS-1:0] meta_q, sync_q, prev_q;
    logic [N_PINS-1:0] edge_q, edge_d, mask_q, rise_en_q, fall_en_q;
    logic [N_PINS-1:0] rise, fall;
    logic [1:0]        arm_q;
    logic              armed;
    logic              irq_q;
    logic [31:0]       rdata_q, rdata_d;
    logic [SEL_W-1:0]  wsel;
    logic              wr_edge, wr_mask, wr_rise, wr_fall;
    logic              unused_wdata;

    assign wsel         = avs_ctrl_writedata[SEL_W-1:0];
    assign unused_wdata = ^avs_ctrl_writedata;
    assign wr_edge      = avs_ctrl_write && (avs_ctrl_address == 5'h01);
    assign wr_mask      = avs_ctrl_write && (avs_ctrl_address == 5'h02);
    assign wr_rise      = avs_ctrl_write && (avs_ctrl_address == 5'h03);
    assign wr_fall      = avs_ctrl_write && (avs_ctrl_address == 5'h04);

    // Only a real change of function reloads the guard; rewriting the same value is harmless.
    always_comb begin
        for (int p = 0; p < N_PINS; p++) begin
            sel_d[p]   = sel_q[p];
            guard_d[p] = (guard_q[p] != 8'd0) ? guard_q[p] - 8'd1 : 8'd0;
            if (avs_ctrl_write && (avs_ctrl_address == (5'h10 + 5'(p))) && (wsel != sel_q[p])) begin
                sel_d[p]   = wsel;
                guard_d[p] = GUARD_L;
            end
        end
    end

    // Edge capture stays off until the synchroniser and prev stage hold real pad data.
    assign armed  = (arm_q == 2'd3);
    assign rise   = sync_q & ~prev_q & rise_en_q;
    assign fall   = ~sync_q & prev_q & fall_en_q;
    assign edge_d = (edge_q & ~(wr_edge ? avs_ctrl_writedata[N_PINS-1:0] : '0))
                  | (armed ? (rise | fall) : '0);

    always_comb begin
        rdata_d = '0;
        case (avs_ctrl_address)
            5'h00:   rdata_d[N_PINS-1:0] = sync_q;
            5'h01:   rdata_d[N_PINS-1:0] = edge_q;
            5'h02:   rdata_d[N_PINS-1:0] = mask_q;
            5'h03:   rdata_d[N_PINS-1:0] = rise_en_q;
            5'h04:   rdata_d[N_PINS-1:0] = fall_en_q;
            default: begin
                for (int p = 0; p < N_PINS; p++) begin
                    if (avs_ctrl_address == (5'h10 + 5'(p))) begin
                        rdata_d[SEL_W-1:0] = sel_q[p];
                        rdata_d[8]         = (guard_q[p] != 8'd0);
                        rdata_d[16]        = sync_q[p];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            for (int p = 0; p < N_PINS; p++) begin
                sel_q[p]   <= '0;
                guard_q[p] <= '0;
            end
            meta_q    <= '0;
            sync_q    <= '0;
            prev_q    <= '0;
            edge_q    <= '0;
            mask_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            arm_q     <= '0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            sel_q   <= sel_d;
            guard_q <= guard_d;
            meta_q  <= coe_GPIO;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            edge_q  <= edge_d;
            if (wr_mask) mask_q    <= avs_ctrl_writedata[N_PINS-1:0];
            if (wr_rise) rise_en_q <= avs_ctrl_writedata[N_PINS-1:0];
            if (wr_fall) fall_en_q <= avs_ctrl_writedata[N_PINS-1:0];
            if (!armed)  arm_q     <= arm_q + 2'd1;
            irq_q <= |(edge_q & mask_q);
            if (avs_ctrl_read) rdata_q <= rdata_d;
        end
    end

    for (genvar p = 0; p < N_PINS; p++) begin : g_pin
        logic [N_FUNCS-1:0] oe_vec, out_vec;
        logic               in_range, drive, out_sel;

        assign oe_vec      = coe_f_oe[p*N_FUNCS +: N_FUNCS];
        assign out_vec     = coe_f_out[p*N_FUNCS +: N_FUNCS];
        assign in_range    = ({1'b0, sel_q[p]} < NF_L);
        assign drive       = in_range && oe_vec[sel_q[p]] && (guard_q[p] == 8'd0);
        assign out_sel     = in_range && out_vec[sel_q[p]];
        assign coe_GPIO[p] = drive ? out_sel : 1'bz;
    end

    assign coe_f_in             = coe_GPIO;
    assign avs_ctrl_readdata    = rdata_q;
    assign avs_ctrl_waitrequest = 1'b0;
    assign ins_irq_irq          = irq_q;
endmodule

// File: tb/tb_qsys_shield_gpio_funcsel_bank.sv
// Bench for the GPIO function-select bank: directed scenarios then random bus/pad traffic against a reference model.
// Undriven pads are pulled high so a tri-stated pin is visible as 1.
module tb_qsys_shield_gpio_funcsel_bank;
    localparam int NP = 8;
    localparam int NF = 6;
    localparam int GC = 4;
    localparam int SW = 3;
    localparam logic [NP-1:0] IN_MASK = 8'h12;

    logic               clk = 1'b0;
    logic               rst;
    logic [4:0]         addr;
    logic [31:0]        wdata;
    logic               wr_s, rd_s;
    logic [31:0]        rdata;
    logic               waitreq, irq;
    logic [NP*NF-1:0]   f_oe, f_out, oe_allow;
    logic [NP-1:0]      f_in;
    logic [NP-1:0]      tb_pad;
    wire  [NP-1:0]      gpio;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    // Reference model state
    int            m_sel   [NP];
    int            m_guard [NP];
    logic [NP-1:0] m_s1, m_sync, m_prev, m_edge, m_mask, m_rise, m_fall;
    int            m_arm;
    logic          m_irq;
    logic          m_valid = 1'b0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NP; i++) begin : g_pad
        pullup pu (gpio[i]);
        assign gpio[i] = IN_MASK[i] ? tb_pad[i] : 1'bz;
    end

    qsys_shield_gpio_funcsel_bank #(.N_PINS(NP), .N_FUNCS(NF), .GUARD_CYCLES(GC)) dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_ctrl_address     (addr),
        .avs_ctrl_writedata   (wdata),
        .avs_ctrl_readdata    (rdata),
        .avs_ctrl_write       (wr_s),
        .avs_ctrl_read        (rd_s),
        .avs_ctrl_waitrequest (waitreq),
        .ins_irq_irq          (irq),
        .coe_f_oe             (f_oe),
        .coe_f_out            (f_out),
        .coe_f_in             (f_in),
        .coe_GPIO             (gpio)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Pad seen by the world: selected function if enabled and not guarded, else bench drive or pull-up.
    function automatic logic [NP-1:0] model_pad();
        logic [NP-1:0] v;
        int f;
        for (int p = 0; p < NP; p++) begin
            f = m_sel[p];
            if (IN_MASK[p]) v[p] = tb_pad[p];
            else            v[p] = 1'b1;
            if (f < NF && m_guard[p] == 0) begin
                if (f_oe[p*NF+f]) v[p] = f_out[p*NF+f];
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        int p;
        v = '0;
        case (a)
            5'h00: v[NP-1:0] = m_sync;
            5'h01: v[NP-1:0] = m_edge;
            5'h02: v[NP-1:0] = m_mask;
            5'h03: v[NP-1:0] = m_rise;
            5'h04: v[NP-1:0] = m_fall;
            default: begin
                p = int'(a) - 16;
                if (p >= 0 && p < NP)
                    v = 32'(m_sel[p]) + ((m_guard[p] != 0) ? 32'h100 : 32'h0) + (m_sync[p] ? 32'h10000 : 32'h0);
            end
        endcase
        return v;
    endfunction

    task automatic model_update(input logic [NP-1:0] ep);
        logic [NP-1:0] det;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                m_sel[p]   = 0;
                m_guard[p] = 0;
            end
            {m_s1, m_sync, m_prev, m_edge, m_mask, m_rise, m_fall} = '0;
            m_arm   = 0;
            m_irq   = 1'b0;
            m_valid = 1'b1;
            return;
        end
        det   = (m_sync & ~m_prev & m_rise) | (~m_sync & m_prev & m_fall);
        m_irq = |(m_edge & m_mask);
        if (wr_s && addr == 5'h01) m_edge = m_edge & ~wdata[NP-1:0];
        if (m_arm >= 3) m_edge = m_edge | det;
        if (wr_s && addr == 5'h02) m_mask = wdata[NP-1:0];
        if (wr_s && addr == 5'h03) m_rise = wdata[NP-1:0];
        if (wr_s && addr == 5'h04) m_fall = wdata[NP-1:0];
        for (int p = 0; p < NP; p++) begin
            if (wr_s && int'(addr) == 16 + p && int'(wdata & 32'h7) != m_sel[p]) begin
                m_sel[p]   = int'(wdata & 32'h7);
                m_guard[p] = GC;
            end else if (m_guard[p] > 0) begin
                m_guard[p] = m_guard[p] - 1;
            end
        end
        m_prev = m_sync;
        m_sync = m_s1;
        m_s1   = ep;
        if (m_arm < 3) m_arm++;
    endtask

    // One clock: inputs were set at the preceding negedge; pads/irq are checked mid-low-phase.
    task automatic cycle();
        logic [NP-1:0] ep;
        #2;
        ep = model_pad();
        if (m_valid) begin
            check("pad", 32'(gpio), 32'(ep));
            check("f_in", 32'(f_in), 32'(ep));
            check("irq", 32'(irq), 32'(m_irq));
        end
        if (rd_s && !rst) exp_q.push_back(model_read(addr));
        @(posedge clk);
        model_update(ep);
        @(negedge clk);
        wr_s = 1'b0;
        rd_s = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_s = 1'b1;
        cycle();
    endtask

    task automatic rd(input logic [4:0] a);
        addr = a; rd_s = 1'b1;
        cycle();
    endtask

    task automatic rdwr(input logic [4:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_s = 1'b1; rd_s = 1'b1;
        cycle();
    endtask

    task automatic set_fn(input int p, input int f, input logic oe, input logic out);
        f_oe[p*NF+f]  = oe;
        f_out[p*NF+f] = out;
    endtask

    // Scoreboard monitor: read data appears one cycle after the read strobe.
    always @(posedge clk) begin
        logic        was_rd;
        logic [31:0] e;
        was_rd = rd_s && !rst;
        #1;
        if (was_rd) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rdq: readdata 0x%0h presented with no expected entry", rdata);
            end else begin
                e = exp_q.pop_front();
                check("rdata", rdata, e);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; wr_s = 1'b0; rd_s = 1'b0;
        f_oe = '0; f_out = '0; tb_pad = 8'h10;
        for (int p = 0; p < NP; p++)
            for (int f = 0; f < NF; f++)
                oe_allow[p*NF+f] = !IN_MASK[p];
        set_fn(0, 0, 1'b1, 1'b1);
        set_fn(0, 1, 1'b1, 1'b0);
        set_fn(2, 3, 1'b1, 1'b0);
        set_fn(2, 4, 1'b1, 1'b0);
        set_fn(2, 5, 1'b1, 1'b0);
        idle(3);
        rst = 1'b0;
        wr(5'h03, 32'hFF);
        check("rdata_rst", rdata, 32'h0);
        check("waitreq", 32'(waitreq), 32'h0);

        for (int a = 0; a < 6; a++) rd(5'(a));
        for (int p = 0; p <= NP; p++) rd(5'(16 + p));
        rd(5'h1F);
        idle(2);

        // Function switch with guard, then same-value rewrite, then reload mid-guard
        wr(5'h12, 32'd3); rd(5'h12); idle(5); rd(5'h12);
        wr(5'h12, 32'd3); idle(3);
        wr(5'h12, 32'd4); idle(1); wr(5'h12, 32'd5); idle(6); rd(5'h12);

        // Rise edge, irq, W1C clear, and set-beats-clear
        wr(5'h02, 32'h02); tb_pad[1] = 1'b1; idle(5); rd(5'h01);
        wr(5'h01, 32'h02); idle(2); rd(5'h01);
        tb_pad[1] = 1'b0; idle(4); tb_pad[1] = 1'b1; idle(2); wr(5'h01, 32'h02); rd(5'h01); idle(2);
        rdwr(5'h02, 32'h0); rd(5'h02);
        wr(5'h04, 32'h12); tb_pad[4] = 1'b0; idle(4); rd(5'h01); rd(5'h00);

        // Out-of-range select tri-states, then a legal one drives after the guard
        wr(5'h10, 32'd7); idle(2); rd(5'h10);
        wr(5'h10, 32'd1); idle(6); rd(5'h10);

        // Reset in the middle of a guard
        wr(5'h13, 32'd2); idle(1); rst = 1'b1; idle(1); rst = 1'b0; idle(3); rd(5'h13);

        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                f_oe  = (NP*NF)'({$urandom, $urandom}) & oe_allow;
                f_out = (NP*NF)'({$urandom, $urandom});
            end
            if ($urandom_range(0, 2) == 0) tb_pad = 8'($urandom) & IN_MASK;
            rst   = ($urandom_range(0, 149) == 0);
            addr  = 5'($urandom_range(0, 31));
            wdata = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: wr_s = 1'b1;
                2: rd_s = !rst;
                default: begin wr_s = 1'b1; rd_s = !rst; end
            endcase
            cycle();
        end
        rst = 1'b0;
        idle(3);
        check("rdq_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
